// File: rtl/mips_run_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encoding, default addresses/limits and address width for the run controller.
package mips_ctrl_pkg;
    localparam int AW = 10;
    localparam logic [AW-1:0] ARG_ADDR_DEF = 10'd200;
    localparam logic [AW-1:0] RES_ADDR_DEF = 10'd198;
    localparam logic [31:0] TIMEOUT_DEF = 32'd1024;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_RUN, S_FETCH, S_DONE} state_t;
endpackage

// File: rtl/mips_run_ctrl_if.sv
// mips_run_ctrl_if: single-word data-memory request/ack bus between the run controller and memory.
interface mips_run_ctrl_if;
    import mips_ctrl_pkg::*;
    logic mem_req;
    logic mem_we;
    logic mem_ack;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_rdata, mem_ack);
    modport slave (input mem_req, mem_we, mem_addr, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mips_run_ctrl_run_cycle_counter.sv
// run_cycle_counter: saturating RUN-cycle counter with clear/enable and a flag for the increment that reaches TIMEOUT.
module run_cycle_counter #(
    parameter logic [31:0] TIMEOUT = 32'd1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clr_i,
    input  logic        en_i,
    output logic [31:0] count_o,
    output logic        tc_o
);
    logic [31:0] count_q, count_d;
    always_comb count_d = clr_i ? '0 : (en_i && count_q != '1) ? count_q + 32'd1 : count_q;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) count_q <= '0;
        else count_q <= count_d;
    assign count_o = count_q;
    assign tc_o = en_i && count_q == TIMEOUT - 32'd1;
endmodule

// File: rtl/mips_run_ctrl.sv
// mips_run_ctrl: loads an operand, runs the core until HLT, fetches its result.
// Optional watchdog abort in RUN enabled by defining MIPS_RUN_CTRL_WATCHDOG_EN.
module mips_run_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter logic [AW-1:0] ARG_ADDR = ARG_ADDR_DEF,
    parameter logic [AW-1:0] RES_ADDR = RES_ADDR_DEF,
    parameter logic [31:0]   TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [31:0]            arg_in,
    mips_run_ctrl_if.master        mem,
    output logic                   core_pc_clr,
    output logic                   core_run,
    input  logic                   core_halted,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            result,
    output logic [31:0]            cycle_count,
    output logic                   timeout_err
);
`ifdef MIPS_RUN_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif
    state_t state_q;
    logic req_q, we_q, clr_q, run_q, busy_q, done_q, to_q, tc;
    logic [AW-1:0] addr_q;
    logic [31:0] arg_q, result_q;
    run_cycle_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .clr_i   (state_q == S_IDLE && start),
        .en_i    (state_q == S_RUN && !core_halted),
        .count_o (cycle_count),
        .tc_o    (tc)
    );
    // Acks are only looked at while already in LOAD/FETCH, so an ack on the entry edge never completes.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            arg_q    <= '0;
            clr_q    <= 1'b0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            to_q     <= 1'b0;
        end else begin
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (start) begin
                    state_q <= S_LOAD;
                    arg_q   <= arg_in;
                    to_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    req_q   <= 1'b1;
                    we_q    <= 1'b1;
                    addr_q  <= ARG_ADDR;
                end
                S_LOAD: if (mem.mem_ack) begin
                    state_q <= S_CLR;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    clr_q   <= 1'b1;
                end
                S_CLR: begin
                    state_q <= S_RUN;
                    run_q   <= 1'b1;
                end
                S_RUN: if (core_halted) begin
                    state_q <= S_FETCH;
                    run_q   <= 1'b0;
                    req_q   <= 1'b1;
                    addr_q  <= RES_ADDR;
                end else if (WD && tc) begin
                    state_q <= S_DONE;
                    run_q   <= 1'b0;
                    to_q    <= 1'b1;
                    done_q  <= 1'b1;
                end
                S_FETCH: if (mem.mem_ack) begin
                    state_q  <= S_DONE;
                    req_q    <= 1'b0;
                    result_q <= mem.mem_rdata;
                    done_q   <= 1'b1;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = arg_q;
    assign core_pc_clr   = clr_q;
    assign core_run      = run_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign result        = result_q;
    assign timeout_err   = to_q;
endmodule

// File: tb/tb_mips_run_ctrl.sv
// tb_mips_run_ctrl: vector table, hand sequences and random jobs against a memory/core model computing factorials.
module tb_mips_run_ctrl;
    import mips_ctrl_pkg::*;
`ifdef MIPS_RUN_CTRL_WATCHDOG_EN
    localparam logic [31:0] TO = 32'd16;
`else
    localparam logic [31:0] TO = 32'd1024;
`endif
    logic clock, reset_n, start, core_pc_clr, core_run, busy, done, timeout_err, halted, stray;
    logic [31:0] arg_in, result, cycle_count;
    logic [31:0] mem_arr [0:1023];
    int lat, core_lat, wcnt, ccnt;
    int total, bad, done_cnt, clr_cnt, meas, unstable;
    logic preq, pwe;
    logic [AW-1:0] paddr;
    logic [31:0] pwd;
    mips_run_ctrl_if bus();
    mips_run_ctrl #(.TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .arg_in(arg_in), .mem(bus),
        .core_pc_clr(core_pc_clr), .core_run(core_run), .core_halted(halted),
        .busy(busy), .done(done), .result(result), .cycle_count(cycle_count), .timeout_err(timeout_err)
    );
    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ref_fact(input logic [31:0] n);
        logic [31:0] f = 32'd1;
        for (int unsigned i = 2; i <= n && i < 64; i++) f = f * i;
        return f;
    endfunction

    assign bus.mem_ack = (bus.mem_req && wcnt >= lat) || stray;
    assign bus.mem_rdata = mem_arr[bus.mem_addr];

    // Memory with programmable ack latency, plus a core that halts core_lat run cycles after PC clear.
    always @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            halted <= 1'b0;
            ccnt <= 0;
            wcnt <= 0;
        end else begin
            wcnt <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1 : 0;
            if (bus.mem_req && bus.mem_ack && bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
            if (core_pc_clr) begin
                halted <= 1'b0;
                ccnt <= 0;
            end else if (core_run && !halted) begin
                ccnt <= ccnt + 1;
                if (ccnt + 1 == core_lat) begin
                    halted <= 1'b1;
                    mem_arr[RES_ADDR_DEF] <= ref_fact(mem_arr[ARG_ADDR_DEF]);
                end
            end
        end

    always @(negedge clock) begin
        if (done) done_cnt++;
        if (core_pc_clr) clr_cnt++;
        if (core_run && !halted) meas++;
        if (bus.mem_req && preq && {bus.mem_addr, bus.mem_we, bus.mem_wdata} != {paddr, pwe, pwd}) unstable++;
        preq = bus.mem_req;
        paddr = bus.mem_addr;
        pwe = bus.mem_we;
        pwd = bus.mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // mode 0: clean; 1: start+stray ack during RUN; 2: stray ack on the LOAD and FETCH entry edges
    task automatic run_job(input logic [31:0] arg, input int l, input int clat, input int mode, input logic [31:0] exp);
        int d0, c0, u0, m0, n;
        bit fired;
        lat = l;
        core_lat = clat;
        @(posedge clock);
        d0 = done_cnt; c0 = clr_cnt; u0 = unstable; m0 = meas;
        @(negedge clock);
        arg_in = arg; start = 1'b1; stray = (mode == 2);
        @(negedge clock);
        start = 1'b0; stray = 1'b0; arg_in = $urandom;
        chk("busy_on", busy, 1);
        chk("req_load", bus.mem_req, 1);
        n = 0;
        fired = 0;
        while (busy && n < 4000) begin
            start = 1'b0;
            stray = 1'b0;
            if (mode == 1 && core_run && !fired) begin start = 1'b1; stray = 1'b1; fired = 1; end
            if (mode == 2 && core_run && halted && !fired) begin stray = 1'b1; fired = 1; end
            @(negedge clock);
            n++;
        end
        start = 1'b0;
        stray = 1'b0;
        chk("job_bound", n < 4000, 1);
        repeat (4) @(negedge clock);
        chk("result", result, exp);
        chk("done_once", done_cnt - d0, 1);
        chk("clr_once", clr_cnt - c0, 1);
        chk("cyc_vs_meas", cycle_count, meas - m0);
        chk("cyc_vs_lat", cycle_count, clat);
        chk("bus_stable", unstable - u0, 0);
        chk("arg_written", mem_arr[ARG_ADDR_DEF], arg);
        chk("idle_after", {busy, core_run, bus.mem_req, timeout_err}, 0);
    endtask

    typedef struct {
        logic [31:0] arg;
        int lat;
        int clat;
        int mode;
        logic [31:0] exp;
    } vec_t;
    vec_t tv [7];

    initial begin
        int d0, m0, n;
        logic [31:0] r0, a;
        tv[0] = '{32'd7, 0, 14, 0, 32'd5040};
        tv[1] = '{32'd1, 0, 5, 0, 32'd1};
        tv[2] = '{32'd7, 3, 12, 0, 32'd5040};
        tv[3] = '{32'd6, 1, 9, 1, 32'd720};
        tv[4] = '{32'd4, 3, 7, 2, 32'd24};
        tv[5] = '{32'd0, 2, 1, 0, 32'd1};
        tv[6] = '{32'd12, 4, 15, 1, 32'd479001600};
        total = 0; bad = 0; done_cnt = 0; clr_cnt = 0; meas = 0; unstable = 0; preq = 1'b0;
        for (int i = 0; i < 1024; i++) mem_arr[i] = '0;
        lat = 0; core_lat = 1; start = 1'b0; stray = 1'b0; arg_in = '0; reset_n = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_bus", {bus.mem_req, bus.mem_we}, 0);
        chk("rst_core", {core_run, core_pc_clr}, 0);
        chk("rst_status", {busy, done, timeout_err}, 0);
        chk("rst_result", result, 0);
        chk("rst_count", cycle_count, 0);
        reset_n = 1'b1;
        @(negedge clock);
        stray = 1'b1;
        @(negedge clock);
        stray = 1'b0;
        chk("idle_stray_ack", {busy, bus.mem_req}, 0);

        for (int i = 0; i < 7; i++) run_job(tv[i].arg, tv[i].lat, tv[i].clat, tv[i].mode, tv[i].exp);

        // Reset while the core is running and never halts.
        lat = 0; core_lat = 0;
        @(posedge clock);
        d0 = done_cnt;
        @(negedge clock);
        arg_in = 32'd9; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (!core_run && n < 50) begin @(negedge clock); n++; end
        chk("run_reached", core_run, 1);
        m0 = meas;
        repeat (10) @(negedge clock);
        chk("hang_run", core_run, 1);
        chk("hang_count", cycle_count, meas - m0);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_bus", {bus.mem_req, bus.mem_we, core_run, core_pc_clr}, 0);
        chk("arst_status", {busy, done, timeout_err}, 0);
        chk("arst_data", result | cycle_count, 0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("arst_no_done", done_cnt - d0, 0);
        run_job(32'd5, 1, 8, 0, 32'd120);

`ifdef MIPS_RUN_CTRL_WATCHDOG_EN
        lat = 0; core_lat = 0;
        r0 = result;
        @(posedge clock);
        d0 = done_cnt; m0 = meas;
        @(negedge clock);
        arg_in = 32'd3; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (busy && n < 500) begin @(negedge clock); n++; end
        chk("wd_bound", n < 500, 1);
        chk("wd_run_cycles", meas - m0, TO);
        chk("wd_count", cycle_count, TO);
        chk("wd_err", timeout_err, 1);
        chk("wd_core_run", core_run, 0);
        chk("wd_result_kept", result, r0);
        chk("wd_done_once", done_cnt - d0, 1);
        run_job(32'd3, 0, 4, 0, 32'd6);
`endif

        for (int i = 0; i < 12; i++) begin
            a = $urandom_range(0, 12);
            run_job(a, $urandom_range(0, 4), $urandom_range(1, 14), $urandom_range(0, 2), ref_fact(a));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
